// File: rtl/load_store_unit.sv
// RV32I load/store unit: single outstanding request, byte/half/word lanes, one-cycle response pulse.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into error responses.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;

    state_e                  state_q, state_d;
    logic                    we_q, we_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [1:0]              offset_q, offset_d;
    logic                    mem_en_q, mem_en_d;
    logic [3:0]              mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]             mem_wdata_q, mem_wdata_d;
    logic                    resp_valid_q, resp_valid_d;
    logic                    resp_err_q, resp_err_d;
    logic [31:0]             resp_rdata_q, resp_rdata_d;

    logic                    req_legal;
    logic [3:0]              store_we;
    logic [31:0]             store_wdata;
    logic [31:0]             rdata_shifted;
    logic [15:0]             rdata_half;
    logic [31:0]             load_data;

    assign req_ready = (state_q == IDLE) && reset;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        req_legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: req_legal = 1'b1;
            3'b100, 3'b101:         req_legal = !req_we;
            default:                req_legal = 1'b0;
        endcase
`ifdef LSU_MISALIGN_TRAP_EN
        if (req_funct3[1:0] == 2'b01 && req_addr[0])
            req_legal = 1'b0;
        if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
            req_legal = 1'b0;
`endif
    end

    // Store lane enables and replicated data; low address bits beyond the access size are ignored.
    always_comb begin
        store_we    = 4'b0000;
        store_wdata = 32'h0;
        case (req_funct3[1:0])
            2'b00: begin
                store_we    = 4'b0001 << req_addr[1:0];
                store_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                store_we    = req_addr[1] ? 4'b1100 : 4'b0011;
                store_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                store_we    = 4'b1111;
                store_wdata = req_wdata;
            end
        endcase
    end

    assign rdata_shifted = mem_rdata >> {offset_q, 3'b000};
    assign rdata_half    = offset_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_data = 32'h0;
        case (funct3_q)
            3'b000:  load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b001:  load_data = {{16{rdata_half[15]}}, rdata_half};
            3'b010:  load_data = mem_rdata;
            3'b100:  load_data = {24'h0, rdata_shifted[7:0]};
            3'b101:  load_data = {16'h0, rdata_half};
            default: load_data = 32'h0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        offset_d     = offset_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 4'b0000;
        mem_addr_d   = '0;
        mem_wdata_d  = 32'h0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    offset_d = req_addr[1:0];
                    if (req_legal) begin
                        state_d     = ACCESS;
                        mem_en_d    = 1'b1;
                        mem_addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_we_d    = req_we ? store_we : 4'b0000;
                        mem_wdata_d = req_we ? store_wdata : 32'h0;
                    end else begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = load_data;
            end
            default: state_d = IDLE;
        endcase
    end

    // Async reset clears mem_en immediately, abandoning any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            offset_q     <= 2'b00;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 4'b0000;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q      <= state_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            offset_q     <= offset_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random requests checked
// against a byte-array memory model. Define LSU_MISALIGN_TRAP_EN for both bench and RTL together.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks;
    int failures;

    logic [31:0] ram [64];
    logic [7:0]  ref_mem [256];

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous data memory: read data appears the cycle after mem_en.
    always @(posedge clk) begin
        if (mem_en) begin
            for (int i = 0; i < 4; i++)
                if (mem_we[i]) ram[mem_addr[7:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
            mem_rdata <= ram[mem_addr[7:2]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request and check every cycle of its lifetime against the memory model.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input string tag);
        int          size;
        int          n;
        logic        legal;
        logic [31:0] base;
        logic [31:0] exp_rd;
        logic [3:0]  exp_we;
        logic [31:0] exp_wd;
        size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd5 && f3 != 3'd3);
`ifdef LSU_MISALIGN_TRAP_EN
        if (addr % 32'(size) != 0) legal = 1'b0;
`endif
        base   = addr & ~(32'(size) - 32'd1);
        exp_we = 4'(((1 << size) - 1) << base[1:0]);
        exp_wd = (size == 1) ? {4{wdata[7:0]}} : (size == 2) ? {2{wdata[15:0]}} : wdata;
        exp_rd = 32'h0;
        for (int i = 0; i < size; i++)
            exp_rd |= 32'(ref_mem[base[7:0] + 8'(i)]) << (8 * i);
        if (!f3[2] && size < 4 && exp_rd[8*size-1])
            exp_rd |= 32'hFFFF_FFFF << (8 * size);

        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        n = 0;
        while (!req_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        check({tag, " ready"}, 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        if (!legal) begin
            check({tag, " err_valid"}, 32'(resp_valid), 32'd1);
            check({tag, " err_flag"}, 32'(resp_err), 32'd1);
            check({tag, " err_rdata"}, resp_rdata, 32'h0);
            check({tag, " err_mem_en"}, 32'(mem_en), 32'd0);
        end else begin
            check({tag, " mem_en"}, 32'(mem_en), 32'd1);
            check({tag, " mem_addr"}, mem_addr, addr & ~32'd3);
            check({tag, " mem_we"}, 32'(mem_we), we ? 32'(exp_we) : 32'd0);
            if (we) check({tag, " mem_wdata"}, mem_wdata, exp_wd);
            check({tag, " early_valid"}, 32'(resp_valid), 32'd0);
            @(negedge clk);
            check({tag, " mem_en_low"}, 32'(mem_en), 32'd0);
            if (we) begin
                for (int i = 0; i < size; i++)
                    ref_mem[base[7:0] + 8'(i)] = wdata[8*i +: 8];
                check({tag, " st_valid"}, 32'(resp_valid), 32'd1);
                check({tag, " st_err"}, 32'(resp_err), 32'd0);
                check({tag, " st_rdata"}, resp_rdata, 32'h0);
            end else begin
                check({tag, " wait_valid"}, 32'(resp_valid), 32'd0);
                @(negedge clk);
                check({tag, " ld_valid"}, 32'(resp_valid), 32'd1);
                check({tag, " ld_err"}, 32'(resp_err), 32'd0);
                check({tag, " ld_rdata"}, resp_rdata, exp_rd);
            end
        end
        @(negedge clk);
        check({tag, " pulse_end"}, 32'(resp_valid), 32'd0);
        check({tag, " ready_again"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int          acc [3];
        int          k;
        int          cyc;
        int          pulses;
        logic [31:0] st_data [3];

        checks     = 0;
        failures   = 0;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        for (int i = 0; i < 64; i++) ram[i] = 32'h0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h0;

        repeat (3) @(negedge clk);
        check("rst ready", 32'(req_ready), 32'd0);
        check("rst mem_en", 32'(mem_en), 32'd0);
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst mem_we", 32'(mem_we), 32'd0);
        reset = 1'b1;
        #1;
        check("post_rst ready", 32'(req_ready), 32'd1);

        // Directed scenarios
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, "sw_10");
        do_req(1'b1, 3'b010, 32'h10, 32'h80FF7F01, "sw_word");
        do_req(1'b0, 3'b000, 32'h13, 32'h0, "lb_13");
        do_req(1'b0, 3'b100, 32'h13, 32'h0, "lbu_13");
        do_req(1'b0, 3'b001, 32'h12, 32'h0, "lh_12");
        check("model lb_13", 32'(ref_mem[8'h13]), 32'h80);
        do_req(1'b1, 3'b000, 32'h21, 32'h000000AB, "sb_21");
        do_req(1'b0, 3'b011, 32'h8, 32'h0, "ld_f3_011");
        do_req(1'b1, 3'b100, 32'h8, 32'h1234, "st_f3_100");
        do_req(1'b1, 3'b010, 32'h4, 32'hCAFEF00D, "sw_4");
        do_req(1'b0, 3'b010, 32'h6, 32'h0, "lw_6");
        do_req(1'b0, 3'b101, 32'h7, 32'h0, "lhu_7");

        // Reset during the ACCESS cycle of a load
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        check("mid_rst ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("mid_rst mem_en_before", 32'(mem_en), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst mem_en_async", 32'(mem_en), 32'd0);
        check("mid_rst ready_low", 32'(req_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_rst no_resp", 32'(resp_valid), 32'd0);
        end
        reset = 1'b1;
        #1;
        check("mid_rst ready_after", 32'(req_ready), 32'd1);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, "lw_after_rst");

        // Three back-to-back stores with req_valid held high
        st_data[0] = 32'h11112222;
        st_data[1] = 32'h33334444;
        st_data[2] = 32'h55556666;
        k      = 0;
        cyc    = 0;
        pulses = 0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h40;
        req_wdata  = st_data[0];
        while (cyc < 30 && (k < 3 || pulses < 3)) begin
            if (resp_valid) pulses++;
            if (req_valid && req_ready) begin
                acc[k] = cyc;
                for (int i = 0; i < 4; i++)
                    ref_mem[8'h40 + 8'(4 * k) + 8'(i)] = st_data[k][8*i +: 8];
                k++;
            end
            @(posedge clk);
            #1;
            if (k >= 3) begin
                req_valid = 1'b0;
            end else begin
                req_addr  = 32'h40 + 32'(4 * k);
                req_wdata = st_data[k];
            end
            @(negedge clk);
            cyc++;
        end
        check("b2b accepts", 32'(k), 32'd3);
        check("b2b pulses", 32'(pulses), 32'd3);
        if (k == 3) begin
            check("b2b gap01", 32'(acc[1] - acc[0]), 32'd3);
            check("b2b gap12", 32'(acc[2] - acc[1]), 32'd3);
        end
        do_req(1'b0, 3'b010, 32'h44, 32'h0, "lw_b2b_1");
        do_req(1'b0, 3'b010, 32'h48, 32'h0, "lw_b2b_2");

        // Random requests against the model
        for (int r = 0; r < 80; r++) begin
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   32'($urandom_range(0, 255)), $urandom, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
